// File: rtl/rca_pipe_pkg.sv
// Shared constants and elaboration helpers for the pipelined ripple-carry adder.
package rca_pipe_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int unsigned slice_width(input int unsigned width,
                                                input int unsigned stages);
        return (stages == 0) ? width : width / stages;
    endfunction

    function automatic bit cfg_is_valid(input int unsigned width, input int unsigned stages);
        return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational SW-bit ripple-carry adder built from full-adder equations.
module rca_slice #(
    parameter int unsigned SW = 4
) (
    input  logic [SW-1:0] x,
    input  logic [SW-1:0] y,
    input  logic          ci,
    output logic [SW-1:0] s,
    output logic          co
);

    logic [SW:0] w_c;

    always_comb begin
        w_c    = '0;
        s      = '0;
        w_c[0] = ci;
        for (int i = 0; i < int'(SW); i++) begin
            s[i]     = x[i] ^ y[i] ^ w_c[i];
            w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
        end
        co = w_c[SW];
    end

endmodule

// File: rtl/rca_pipelined_param.sv
// WIDTH-bit add/subtract split into STAGES registered ripple slices with valid/ready and stall.
// Define OVERFLOW_EN to add the pipelined signed-overflow output ovf.
module rca_pipelined_param
    import rca_pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int unsigned SW = slice_width(WIDTH, STAGES);

    if (!cfg_is_valid(WIDTH, STAGES)) begin : g_cfg_error
        $error("rca_pipelined_param: WIDTH must be a nonzero multiple of STAGES");
    end

    logic             w_stall;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;

    // Subtract is a + ~b + ~cin, so b is inverted once on entry and skewed already inverted.
    assign w_b_eff   = (sub == OP_ADD) ? b : ~b;
    assign w_cin_eff = (sub == OP_SUB) ? ~cin : cin;
    assign w_stall   = out_valid && !out_ready;
    assign in_ready  = !w_stall;

    for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
        localparam int unsigned PW = WIDTH - k * SW;
        localparam int unsigned LW = (k + 1) * SW;

        logic [PW-1:0] w_a_in;
        logic [PW-1:0] w_b_in;
        logic          w_v_in;
        logic          w_c_in;
        logic [SW-1:0] w_s;
        logic          w_co;
        logic [LW-1:0] w_s_next;

        logic          r_v;
        logic          r_c;
        logic [LW-1:0] r_s;

        if (k == 0) begin : g_head
            assign w_a_in   = a;
            assign w_b_in   = w_b_eff;
            assign w_v_in   = in_valid;
            assign w_c_in   = w_cin_eff;
            assign w_s_next = w_s;
        end else begin : g_body
            assign w_a_in   = g_stage[k-1].g_skew.r_a;
            assign w_b_in   = g_stage[k-1].g_skew.r_b;
            assign w_v_in   = g_stage[k-1].r_v;
            assign w_c_in   = g_stage[k-1].r_c;
            assign w_s_next = {w_s, g_stage[k-1].r_s};
        end

        rca_slice #(
            .SW(SW)
        ) u_slice (
            .x (w_a_in[SW-1:0]),
            .y (w_b_in[SW-1:0]),
            .ci(w_c_in),
            .s (w_s),
            .co(w_co)
        );

        always_ff @(posedge clock) begin
            if (reset) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (!w_stall) begin
                r_v <= w_v_in;
                r_c <= w_co;
                r_s <= w_s_next;
            end
        end

        // Operand bits not yet consumed travel alongside the beat.
        if (k < int'(STAGES) - 1) begin : g_skew
            logic [PW-SW-1:0] r_a;
            logic [PW-SW-1:0] r_b;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (!w_stall) begin
                    r_a <= w_a_in[PW-1:SW];
                    r_b <= w_b_in[PW-1:SW];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].r_v;
    assign sum       = g_stage[STAGES-1].r_s;
    assign cout      = g_stage[STAGES-1].r_c;

`ifdef OVERFLOW_EN
    logic w_c_msb;
    logic r_ovf;

    // Carry into the MSB recovered from the MSB sum bit and its operand bits.
    assign w_c_msb = g_stage[STAGES-1].w_s[SW-1] ^ g_stage[STAGES-1].w_a_in[SW-1]
                   ^ g_stage[STAGES-1].w_b_in[SW-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (!w_stall) begin
            r_ovf <= w_c_msb ^ g_stage[STAGES-1].w_co;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: doc/rca_pipelined_param.md
Name: rca_pipelined_param

Overview:
Parametrised successor to the fixed 4-bit pipelined ripple-carry adder. It splits a WIDTH-bit add/subtract into STAGES registered ripple-carry slices. Each slice's carry is registered into the next slice, and operand and result slices are skewed and de-skewed so that one operation is accepted per cycle. It adds valid/ready flow control, a subtract mode, and a full-pipeline stall, and sits as the datapath arithmetic unit behind any producer/consumer pair.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
STAGES, 4, number of pipeline stages (ripple slices); slice width SW = WIDTH/STAGES; STAGES >= 1.

Ports:
clock  in  1  single clock; all registers update on the rising edge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  operand beat present.
in_ready  out  1  block can accept a beat this cycle.
a  in  WIDTH  operand A (unsigned, or two's complement).
b  in  WIDTH  operand B.
cin  in  1  carry-in (add) / borrow-in (sub).
sub  in  1  0 = add, 1 = subtract.
out_valid  out  1  result beat present.
out_ready  in  1  consumer accepts the result.
sum  out  WIDTH  result.
cout  out  1  carry-out (add) / NOT borrow-out (sub).

Behaviour:
- Arithmetic:
  - sub=0: {cout,sum} = a + b + cin.
  - sub=1: {cout,sum} = a + ~b + (cin ^ 1), i.e. a - b - cin.
  - In sub mode, cout=1 means no borrow.
  - All results are modulo 2^WIDTH, with the carry taken from the top slice.
- Pipeline structure:
  - Stage k (0..STAGES-1) adds bits [k*SW +: SW] using the carry registered by stage k-1.
  - Stage 0 uses the effective carry-in cin ^ sub.
  - Upper operand slices (with b already inverted on entry when sub=1) are carried forward in skew registers.
  - Completed lower sum slices are carried forward in de-skew registers.
- Latency: exactly STAGES cycles from an accepted beat (in_valid && in_ready at edge t) to out_valid=1 with that result after edge t+STAGES-1, assuming no stall.
- Throughput: one beat per cycle.
- Per-stage valid bit: v[0..STAGES-1]; out_valid = v[STAGES-1].
- Stall:
  - stall = out_valid && !out_ready.
  - While stall is high, every stage register (data, carry, valid) holds.
  - in_ready = !stall, so the input is not accepted during a stall.
- Bubbles: when in_valid=0 and there is no stall, a bubble (v=0) enters stage 0. Bubbles are never presented as out_valid.
- Output hold: sum and cout hold their value while out_valid=1 and out_ready=0.
- Simultaneous events: out_valid && out_ready with in_valid in the same cycle gives a full-rate shift with no bubble inserted.
- Reset:
  - While reset=1, all v[] are 0 and every data and carry register is 0.
  - Outputs under reset: out_valid=0, sum=0, cout=0, in_ready=1.
  - Reset mid-operation discards all in-flight beats. The next edge after reset deasserts starts from an empty pipe.
  - Inputs are ignored while reset=1.
- STAGES=1: the block degenerates to a single registered WIDTH-bit adder with latency 1.

Optional Feature:
Macro OVERFLOW_EN.
- Defined:
  - Adds output port ovf (out, 1): two's-complement signed overflow, equal to the carry into the MSB XOR cout.
  - ovf is pipelined with the result, resets to 0, and holds during a stall.
- Undefined:
  - No ovf port and no extra logic.
  - All other behaviour is identical.

Decomposition:
- Package rca_pipe_pkg:
  - localparam-style function for SW = WIDTH/STAGES.
  - Constant OP_ADD=1'b0, OP_SUB=1'b1.
  - Elaboration check that WIDTH % STAGES == 0.
- Sub-module rca_slice:
  - Combinational SW-bit ripple adder: inputs x, y, ci; outputs s, co.
  - Built from full-adder equations.
  - Instantiated STAGES times via generate.
- All registers live in rca_pipelined_param.

Test Plan:
1. Reset 2 cycles, then one beat a=0x1234, b=0x4321, cin=0, sub=0 -> out_valid high exactly 4 cycles after acceptance; sum=0x5555, cout=0; out_valid=0 on all other cycles.
2. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry ripples through every stage register).
3. Subtract cases, each checking cout:
   - a=0x0005, b=0x0007, sub=1, cin=0 -> sum=0xFFFE, cout=0.
   - a=0x0007, b=0x0005, sub=1, cin=1 -> sum=0x0001, cout=1.
4. Stream 8 back-to-back beats (a=i, b=2i); drop out_ready for 3 cycles at cycle 6:
   - in_ready=0 and sum/cout held during the stall.
   - All 8 results arrive in order with no loss or duplication.
   - Throughput is 1/cycle otherwise.
5. Reset asserted 2 cycles into a stream of 3 beats -> out_valid stays 0 after the reset edge, no stale results ever appear, and the first post-reset beat completes with correct latency.
6. With OVERFLOW_EN defined:
   - 0x7FFF + 0x0001 -> sum=0x8000, ovf=1.
   - 0x8000 - 0x0001 -> sum=0x7FFF, ovf=1.
   - 0x0003 + 0x0004 -> ovf=0.
